instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the fetch address loaded on reset.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetl  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port NextPC  input  64  redirect target from the next-PC logic.
REQ-005 SHALL have port Redirect  input  1  taken branch or unconditional branch; load NextPC and flush.
REQ-006 SHALL have port CurrentPC  output  64  fetch PC register, fed to the next-PC logic.
REQ-007 SHALL have port ImemReq  output  1  instruction-memory read request.
REQ-008 SHALL have port ImemAddr  output  64  read address; always equal to CurrentPC.
REQ-009 SHALL have port ImemAck  input  1  read complete; ImemData valid in the same cycle.
REQ-010 SHALL have port ImemData  input  32  fetched instruction word.
REQ-011 SHALL have port InstrValid  output  1  head of the instruction buffer is valid.
REQ-012 SHALL have port Instr  output  32  instruction word at the buffer head.
REQ-013 SHALL have port InstrPC  output  64  address of Instr.
REQ-014 SHALL have port DecReady  input  1  decode accepts the head entry.

Function
REQ-015 SHALL contain a 2-entry FIFO of {Instr, InstrPC} with a count of 0..2.
REQ-016 SHALL implement the FSM states FETCH (ImemReq=1) and FULL (ImemReq=0).
REQ-017 SHALL be in FETCH when count<2 after the edge and in FULL when count==2 after the edge; Redirect always forces FETCH.
REQ-018 SHALL drive ImemReq as the registered state only; it SHALL NOT depend combinationally on ImemAck.
REQ-019 SHALL treat a handshake as ImemReq&ImemAck&!Redirect on a rising edge; ImemAddr SHALL stay stable while it waits for ImemAck.
REQ-020 SHALL, on a handshake, push {ImemData, CurrentPC} and set CurrentPC to CurrentPC+4, modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC wraps to 0).
REQ-021 SHALL treat a pop as InstrValid&DecReady&!Redirect; a pop SHALL advance the head.
REQ-022 SHALL leave count unchanged on a simultaneous push and pop, and SHALL preserve FIFO order.
REQ-023 SHALL drive InstrValid=(count!=0); Instr and InstrPC SHALL be registered outputs that are stable while InstrValid=1 and DecReady=0.
REQ-024 SHALL, on Redirect=1 at an edge, set CurrentPC=NextPC, set count=0 and enter FETCH; any ImemAck or pop in that cycle SHALL be discarded.
REQ-025 SHALL give Redirect priority over handshake, pop and the PC increment.
REQ-026 SHALL have a latency of one cycle from handshake edge to InstrValid=1, and a sustained throughput of one instruction per cycle when ImemAck=1 and DecReady=1.
REQ-027 SHALL accept ImemAck while ImemReq=0 without effect.
REQ-028 SHALL ignore the low two bits of NextPC; they SHALL be loaded unchanged, with no alignment check.

Reset
REQ-029 SHALL, while resetl=0, force CurrentPC=RESET_PC, count=0, InstrValid=0, Instr=0, InstrPC=0, state FETCH and ImemReq=1, independent of CLK.
REQ-030 SHALL, after resetl rises, issue its first request at RESET_PC; a reset during a pending request SHALL abandon that request.

Verification
REQ-031 SHALL be verified for reset and streaming: RESET_PC=0x100, ImemAck=1 always, DecReady=1 -> InstrPC sequence 0x100, 0x104, 0x108, one per cycle, with the first InstrValid one cycle after the first ack.
REQ-032 SHALL be verified for back-pressure: DecReady=0 and 3 acks offered -> 2 pushes, ImemReq=0 after the second, CurrentPC=RESET_PC+8; DecReady=1 -> ImemReq=1 the next cycle.
REQ-033 SHALL be verified for redirect with an ack in the same cycle: count=1, Redirect=1, NextPC=0x2000, ImemAck=1 -> count=0, data dropped, next ImemAddr=0x2000.
REQ-034 SHALL be verified for wait states: ImemAck held low 3 cycles -> ImemAddr stable and ImemReq=1 throughout, with no push.
REQ-035 SHALL be verified for wrap-around: CurrentPC=0xFFFF_FFFF_FFFF_FFFC, one ack -> CurrentPC=0, InstrPC=0xFFFF_FFFF_FFFF_FFFC.
REQ-036 SHALL be verified for asynchronous reset: resetl low mid-stream between edges -> outputs at reset values immediately, before the next CLK edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Sequential instruction fetcher with a 2-entry instruction buffer.
//   Requests one 32-bit word at a time from instruction memory, tags it with
//   its fetch address and queues it for the decode stage. A redirect from the
//   next-PC logic reloads the fetch PC and flushes the buffer.
//
// Ports
//   CLK         in   1   clock, all state updates on the rising edge
//   resetl      in   1   asynchronous active-low reset
//   NextPC      in   64  redirect target
//   Redirect    in   1   load NextPC and flush the buffer
//   CurrentPC   out  64  fetch PC register
//   ImemReq     out  1   instruction-memory read request (registered state)
//   ImemAddr    out  64  read address, always equal to CurrentPC
//   ImemAck     in   1   read complete, ImemData valid this cycle
//   ImemData    in   32  fetched instruction word
//   InstrValid  out  1   buffer head valid
//   Instr       out  32  instruction at the buffer head
//   InstrPC     out  64  address of Instr
//   DecReady    in   1   decode accepts the head entry
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] NextPC,
  input  logic        Redirect,
  output logic [63:0] CurrentPC,
  output logic        ImemReq,
  output logic [63:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [63:0] InstrPC,
  input  logic        DecReady
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [63:0] pc_q, pc_d;
  // Buffer is a two-register shift queue: head drives the outputs directly.
  logic [31:0] head_instr_q, head_instr_d;
  logic [63:0] head_pc_q, head_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;
  logic [63:0] tail_pc_q, tail_pc_d;
  logic        push_s;
  logic        pop_s;

  assign ImemReq    = (state_q == ST_FETCH);
  assign CurrentPC  = pc_q;
  assign ImemAddr   = pc_q;
  assign InstrValid = (count_q != 2'd0);
  assign Instr      = head_instr_q;
  assign InstrPC    = head_pc_q;

  // Redirect suppresses both the memory handshake and the decode pop.
  assign push_s = ImemReq & ImemAck & ~Redirect;
  assign pop_s  = InstrValid & DecReady & ~Redirect;

  // Next-state for PC, buffer occupancy, buffer contents and FSM.
  always_comb begin
    pc_d         = pc_q;
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    state_d      = state_q;

    if (Redirect) begin
      // NextPC is loaded verbatim, low bits included.
      pc_d    = NextPC;
      count_d = 2'd0;
    end else begin
      if (push_s) begin
        pc_d = pc_q + 64'd4;
      end else begin
        pc_d = pc_q;
      end

      case ({push_s, pop_s})
        2'b10: begin
          count_d = count_q + 2'd1;
          if (count_q == 2'd0) begin
            head_instr_d = ImemData;
            head_pc_d    = pc_q;
          end else begin
            tail_instr_d = ImemData;
            tail_pc_d    = pc_q;
          end
        end
        2'b01: begin
          count_d = count_q - 2'd1;
          if (count_q == 2'd2) begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
          end else begin
            head_instr_d = head_instr_q;
            head_pc_d    = head_pc_q;
          end
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          count_d = count_q;
          if (count_q == 2'd2) begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
            tail_instr_d = ImemData;
            tail_pc_d    = pc_q;
          end else begin
            head_instr_d = ImemData;
            head_pc_d    = pc_q;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end

    if (count_d == 2'd2) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_FETCH;
    end
  end

  // State, PC and buffer registers.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q      <= ST_FETCH;
      count_q      <= 2'd0;
      pc_q         <= RESET_PC;
      head_instr_q <= 32'd0;
      head_pc_q    <= 64'd0;
      tail_instr_q <= 32'd0;
      tail_pc_q    <= 64'd0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      pc_q         <= pc_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed scenarios with literal expectations followed by a randomized
//   phase, all cross-checked every cycle against a queue-based model.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        CLK;
  logic        resetl;
  logic [63:0] NextPC;
  logic        Redirect;
  logic [63:0] CurrentPC;
  logic        ImemReq;
  logic [63:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic        DecReady;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .resetl(resetl), .NextPC(NextPC), .Redirect(Redirect),
    .CurrentPC(CurrentPC), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemAck(ImemAck), .ImemData(ImemData), .InstrValid(InstrValid),
    .Instr(Instr), .InstrPC(InstrPC), .DecReady(DecReady)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: buffer is a queue of {instr, pc}; request whenever it has room.
  logic [95:0] m_q[$];
  logic [63:0] m_pc = RST_PC;

  always @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      m_q.delete();
      m_pc = RST_PC;
    end else begin
      automatic bit req  = (m_q.size() < 2);
      automatic bit push = req && ImemAck && !Redirect;
      automatic bit pop  = (m_q.size() != 0) && DecReady && !Redirect;
      if (Redirect) begin
        m_q.delete();
        m_pc = NextPC;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (push) begin
          m_q.push_back({ImemData, m_pc});
          m_pc = m_pc + 64'd4;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    if (resetl === 1'b1) begin
      chk("m_ImemReq", {63'd0, ImemReq}, {63'd0, (m_q.size() < 2)});
      chk("m_CurrentPC", CurrentPC, m_pc);
      chk("m_ImemAddr", ImemAddr, m_pc);
      chk("m_InstrValid", {63'd0, InstrValid}, {63'd0, (m_q.size() != 0)});
      if (m_q.size() != 0) begin
        chk("m_Instr", {32'd0, Instr}, {32'd0, m_q[0][95:64]});
        chk("m_InstrPC", InstrPC, m_q[0][63:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive(input logic rd, input logic [63:0] np, input logic ack, input logic rdy);
    Redirect = rd;
    NextPC   = np;
    ImemAck  = ack;
    DecReady = rdy;
    ImemData = $urandom;
  endtask

  initial begin
    resetl = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    repeat (2) cyc();
    chk("rst_CurrentPC", CurrentPC, 64'h100);
    chk("rst_ImemReq", {63'd0, ImemReq}, 64'd1);
    chk("rst_InstrValid", {63'd0, InstrValid}, 64'd0);
    chk("rst_Instr", {32'd0, Instr}, 64'd0);
    chk("rst_InstrPC", InstrPC, 64'd0);

    // Streaming: one instruction per cycle, first valid one cycle after first ack.
    resetl = 1'b1;
    drive(1'b0, 64'd0, 1'b1, 1'b1);
    cyc();
    chk("str_valid0", {63'd0, InstrValid}, 64'd1);
    chk("str_pc0", InstrPC, 64'h100);
    ImemData = $urandom;
    cyc();
    chk("str_pc1", InstrPC, 64'h104);
    ImemData = $urandom;
    cyc();
    chk("str_pc2", InstrPC, 64'h108);

    // Back-pressure: three acks offered, only two accepted.
    drive(1'b1, 64'h100, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    cyc();
    ImemData = $urandom;
    cyc();
    chk("bp_req_after2", {63'd0, ImemReq}, 64'd0);
    ImemData = $urandom;
    cyc();
    chk("bp_req_after3", {63'd0, ImemReq}, 64'd0);
    chk("bp_CurrentPC", CurrentPC, 64'h108);
    chk("bp_head", InstrPC, 64'h100);
    drive(1'b0, 64'd0, 1'b0, 1'b1);
    cyc();
    chk("bp_req_resume", {63'd0, ImemReq}, 64'd1);
    chk("bp_head_next", InstrPC, 64'h104);

    // Redirect with an ack in the same cycle.
    drive(1'b1, 64'h1000, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    cyc();
    chk("rd_count1", {63'd0, InstrValid}, 64'd1);
    drive(1'b1, 64'h2000, 1'b1, 1'b1);
    cyc();
    chk("rd_valid", {63'd0, InstrValid}, 64'd0);
    chk("rd_addr", ImemAddr, 64'h2000);

    // Wait states: address and request held, nothing pushed.
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ws_req", {63'd0, ImemReq}, 64'd1);
      chk("ws_addr", ImemAddr, 64'h2000);
      chk("ws_valid", {63'd0, InstrValid}, 64'd0);
    end
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    ImemData = 32'hDEAD_BEEF;
    cyc();
    chk("ws_instr", {32'd0, Instr}, 64'h0000_0000_DEAD_BEEF);
    chk("ws_instrpc", InstrPC, 64'h2000);

    // Misaligned redirect target is loaded unchanged.
    drive(1'b1, 64'h3003, 1'b0, 1'b0);
    cyc();
    chk("mis_pc", CurrentPC, 64'h3003);

    // Wrap-around of the fetch PC.
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    ImemData = 32'h1234_5678;
    cyc();
    chk("wrap_pc", CurrentPC, 64'd0);
    chk("wrap_instrpc", InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr", {32'd0, Instr}, 64'h0000_0000_1234_5678);

    // Asynchronous reset between edges while streaming.
    drive(1'b0, 64'd0, 1'b1, 1'b1);
    cyc();
    @(posedge CLK);
    #2 resetl = 1'b0;
    #1;
    chk("ar_CurrentPC", CurrentPC, 64'h100);
    chk("ar_ImemReq", {63'd0, ImemReq}, 64'd1);
    chk("ar_InstrValid", {63'd0, InstrValid}, 64'd0);
    chk("ar_Instr", {32'd0, Instr}, 64'd0);
    chk("ar_InstrPC", InstrPC, 64'd0);
    @(negedge CLK);
    resetl = 1'b1;
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    cyc();
    chk("ar_first_pc", InstrPC, 64'h100);

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 15) == 0), {$urandom, $urandom},
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
